// File: rtl/cpu_types_pkg.sv
// CPU-wide shared types: the machine word and the RAM handshake status.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/diaosi_types_pkg.sv
// Memory-controller types: arbiter state encoding and the default error word.
package diaosi_types_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DACC = 2'd1,
    IACC = 2'd2,
    HIT  = 2'd3
  } memctl_state_t;

  localparam logic [31:0] ERR_WORD_DEFAULT = 32'hBAD1BAD1;

endpackage

// File: rtl/memctl_watchdog.sv
// Access timeout counter: cleared by start_i, counts tick_i cycles and flags the
// tick that would reach TIMEOUT_CYCLES. Used by memory_control only under MEMCTL_TIMEOUT_EN.
module memctl_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic CLK,
  input  logic nRST,
  input  logic start_i,
  input  logic tick_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count_q, count_d;

  // Fires on the stalled cycle that completes the budget, so the abort lands on that edge.
  assign expired_o = tick_i && (count_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    count_d = count_q;
    if (start_i) begin
      count_d = '0;
    end else if (tick_i && !expired_o) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/memory_control.sv
// Single-port RAM arbiter for instruction fetch and data access; data has priority.
// Optional access timeout is enabled by defining MEMCTL_TIMEOUT_EN.
module memory_control
  import cpu_types_pkg::*;
  import diaosi_types_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter word_t       ERR_WORD       = ERR_WORD_DEFAULT
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        ihit,
  output logic [31:0] iload,
  output logic        dhit,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        mem_err
);

  memctl_state_t state_q, state_d;
  word_t         addr_q, addr_d;
  word_t         data_q, data_d;
  logic          write_q, write_d;
  logic          ihit_q, ihit_d;
  logic          dhit_q, dhit_d;
  word_t         iload_q, iload_d;
  word_t         dload_q, dload_d;
  logic          mem_err_q, mem_err_d;

  ramstate_t ram_st;
  logic      in_access;
  logic      timed_out;

  assign ram_st    = ramstate_t'(ramstate);
  assign in_access = (state_q == DACC) || (state_q == IACC);

`ifdef MEMCTL_TIMEOUT_EN
  logic wd_start;
  logic wd_tick;

  assign wd_start = (state_q == IDLE) && ((state_d == DACC) || (state_d == IACC));
  assign wd_tick  = in_access && (ram_st != ACCESS) && (ram_st != ERROR);

  memctl_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .CLK      (CLK),
    .nRST     (nRST),
    .start_i  (wd_start),
    .tick_i   (wd_tick),
    .expired_o(timed_out)
  );
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timed_out          = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    write_d   = write_q;
    ihit_d    = 1'b0;
    dhit_d    = 1'b0;
    iload_d   = iload_q;
    dload_d   = dload_q;
    mem_err_d = mem_err_q;

    case (state_q)
      IDLE: begin
        if (dREN || dWEN) begin
          state_d = DACC;
          addr_d  = daddr;
          data_d  = dstore;
          write_d = dWEN;
        end else if (iREN) begin
          state_d = IACC;
          addr_d  = iaddr;
          write_d = 1'b0;
        end
      end

      DACC, IACC: begin
        if (ram_st == ACCESS) begin
          state_d = HIT;
          if (state_q == IACC) begin
            ihit_d  = 1'b1;
            iload_d = ramload;
          end else begin
            dhit_d = 1'b1;
            if (!write_q) begin
              dload_d = ramload;
            end
          end
        end else if ((ram_st == ERROR) || timed_out) begin
          // Failed accesses still complete so the requester never stalls forever.
          state_d   = HIT;
          mem_err_d = 1'b1;
          if (state_q == IACC) begin
            ihit_d  = 1'b1;
            iload_d = ERR_WORD;
          end else begin
            dhit_d  = 1'b1;
            dload_d = ERR_WORD;
          end
        end
      end

      HIT: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      write_q   <= 1'b0;
      ihit_q    <= 1'b0;
      dhit_q    <= 1'b0;
      iload_q   <= '0;
      dload_q   <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      write_q   <= write_d;
      ihit_q    <= ihit_d;
      dhit_q    <= dhit_d;
      iload_q   <= iload_d;
      dload_q   <= dload_d;
      mem_err_q <= mem_err_d;
    end
  end

  // RAM side decodes straight from the state register so reset drops it immediately.
  assign ramREN   = in_access && !write_q;
  assign ramWEN   = in_access && write_q;
  assign ramaddr  = in_access ? addr_q : '0;
  assign ramstore = (in_access && write_q) ? data_q : '0;

  assign ihit    = ihit_q;
  assign dhit    = dhit_q;
  assign iload   = iload_q;
  assign dload   = dload_q;
  assign mem_err = mem_err_q;

endmodule
